// File: rtl/axis_1553_decoder.sv
// MIL-STD-1553 Manchester receive decoder with an AXI-Stream master output.
// Samples diff through a two-flop synchronizer, qualifies the 3-bit-time sync,
// recovers 16 data bits plus parity on fixed timing from the sync transition,
// and presents each word with its sync type and parity status in tuser.
module axis_1553_decoder #(
  parameter int clock_speed = 16000000
) (
  input  logic        aclk,
  input  logic        arstn,
  input  logic [1:0]  diff,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [7:0]  m_axis_tuser,
  output logic        rx_err,
  output logic        rx_overflow
);

  function automatic int clogb2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = value - 1;
    r = 0;
    while (v != 0) begin
      r++;
      v = v >> 1;
    end
    return int'(r);
  endfunction

  localparam int SPB = clock_speed / 1000000;
  localparam int CW  = clogb2(20 * SPB) + 1;

  localparam logic [CW-1:0] RUN_MIN    = CW'(3 * SPB / 2 - SPB / 4);
  localparam logic [CW-1:0] RUN_MAX    = CW'(3 * SPB / 2 + SPB / 4);
  localparam logic [CW-1:0] TAIL_MAX   = CW'(SPB / 2);
  localparam logic [CW-1:0] SYNC2_LAST = CW'(3 * SPB / 2 - 1);
  localparam logic [CW-1:0] PH_FIRST   = CW'(SPB / 4);
  localparam logic [CW-1:0] PH_SECOND  = CW'(3 * SPB / 4);
  localparam logic [CW-1:0] PH_LAST    = CW'(SPB - 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC1,
    SYNC2,
    BITS,
    CHECK
  } state_t;

  logic [1:0]    sync_q1, sync_q2;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:0]    bit_k, bit_k_n;
  logic          first_hi, first_hi_n;
  logic          half_hi, half_hi_n;
  logic [16:0]   shreg, shreg_n;
  logic          err_n;
  logic          word_done;
  logic          load_word;
  logic          ovf_n;
  logic          lvl_ok;
  logic          lvl_hi;

  // Two-flop synchronizer for the asynchronous line receiver output.
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= diff;
      sync_q2 <= sync_q1;
    end
  end

  assign lvl_ok = (sync_q2 == 2'b01) || (sync_q2 == 2'b10);
  assign lvl_hi = (sync_q2 == 2'b01);

  // Decoder state and working registers.
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_k    <= '0;
      first_hi <= 1'b0;
      half_hi  <= 1'b0;
      shreg    <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_k    <= bit_k_n;
      first_hi <= first_hi_n;
      half_hi  <= half_hi_n;
      shreg    <= shreg_n;
    end
  end

  // Next-state logic. cnt is the sync run length in SYNC1, the offset from the
  // sync transition in SYNC2, and the sample phase within the current bit in BITS.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_k_n    = bit_k;
    first_hi_n = first_hi;
    half_hi_n  = half_hi;
    shreg_n    = shreg;
    err_n      = 1'b0;
    word_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (lvl_ok) begin
          state_n    = SYNC1;
          cnt_n      = CW'(1);
          first_hi_n = lvl_hi;
        end
      end
      SYNC1: begin
        if (!lvl_ok) begin
          // A short run ending in idle is the tail of the previous word's last
          // half-bit (the decoder returns to IDLE before the line does), not a sync.
          state_n = IDLE;
          err_n   = (cnt >= TAIL_MAX);
        end else if (lvl_hi == first_hi) begin
          if (cnt == RUN_MAX) begin
            state_n = IDLE;
            err_n   = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end else if ((cnt >= RUN_MIN) && (cnt <= RUN_MAX)) begin
          state_n = SYNC2;
          cnt_n   = CW'(1);
        end else begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end
      SYNC2: begin
        if (cnt == SYNC2_LAST) begin
          state_n = BITS;
          cnt_n   = '0;
          bit_k_n = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      BITS: begin
        if (cnt == PH_LAST) begin
          cnt_n   = '0;
          bit_k_n = bit_k + 5'd1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
        if (cnt == PH_FIRST) begin
          if (!lvl_ok) begin
            state_n = IDLE;
            err_n   = 1'b1;
          end else begin
            half_hi_n = lvl_hi;
          end
        end
        if (cnt == PH_SECOND) begin
          if (!lvl_ok || (lvl_hi == half_hi)) begin
            state_n = IDLE;
            err_n   = 1'b1;
          end else begin
            shreg_n = {shreg[15:0], lvl_hi};
            if (bit_k == 5'd16) begin
              state_n = CHECK;
            end
          end
        end
      end
      CHECK: begin
        state_n   = IDLE;
        word_done = 1'b1;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // A finished word may load when the register is empty or draining this cycle.
  always_comb begin
    load_word = word_done && (!m_axis_tvalid || m_axis_tready);
    ovf_n     = word_done && !load_word;
  end

  // AXI-Stream output register and status pulses.
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tvalid <= 1'b0;
      rx_err        <= 1'b0;
      rx_overflow   <= 1'b0;
    end else begin
      rx_err      <= err_n;
      rx_overflow <= ovf_n;
      if (load_word) begin
        m_axis_tdata  <= shreg[16:1];
        m_axis_tuser  <= {(first_hi ? 3'b010 : 3'b100), 4'b0000, ~^shreg};
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_1553_decoder.sv
// Directed bench for axis_1553_decoder: drives Manchester words on diff at
// 16 samples per bit and checks decoded beats against a scoreboard queue.
module tb_axis_1553_decoder;

  localparam int SPB = 16;
  localparam logic [1:0] HI = 2'b01;
  localparam logic [1:0] LO = 2'b10;
  localparam logic [1:0] IL = 2'b00;

  logic        aclk;
  logic        arstn;
  logic [1:0]  diff;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [7:0]  m_axis_tuser;
  logic        rx_err;
  logic        rx_overflow;

  axis_1553_decoder #(.clock_speed(16000000)) dut (
    .aclk          (aclk),
    .arstn         (arstn),
    .diff          (diff),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .rx_err        (rx_err),
    .rx_overflow   (rx_overflow)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  u;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_push = 0;

  int   beats = 0;
  int   err_cnt = 0;
  int   ovf_cnt = 0;
  logic prev_err = 1'b0;
  logic prev_ovf = 1'b0;
  logic viol = 1'b0;

  // Event counters and pulse-shape watch on the DUT outputs.
  always @(posedge aclk) begin
    if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) beats <= beats + 1;
    if (rx_err === 1'b1) err_cnt <= err_cnt + 1;
    if (rx_overflow === 1'b1) ovf_cnt <= ovf_cnt + 1;
    if ((rx_err === 1'b1 && rx_overflow === 1'b1) ||
        (rx_err === 1'b1 && prev_err === 1'b1) ||
        (rx_overflow === 1'b1 && prev_ovf === 1'b1)) viol <= 1'b1;
    prev_err <= rx_err;
    prev_ovf <= rx_overflow;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [1:0] lv, input int n);
    for (int i = 0; i < n; i++) begin
      diff = lv;
      @(negedge aclk);
    end
  endtask

  task automatic send_sync(input logic cmd, input int first_len);
    logic [1:0] f;
    f = cmd ? LO : HI;
    put(f, first_len);
    put(~f, 3 * SPB / 2);
  endtask

  task automatic send_bit(input logic b);
    logic [1:0] f;
    f = b ? LO : HI;
    put(f, SPB / 2);
    put(~f, SPB / 2);
  endtask

  // Full word; glitch_k >= 0 forces 4 idle samples into that bit's first half
  // and abandons the rest of the word.
  task automatic send_word(input logic cmd, input logic [15:0] data, input logic odd,
                           input int first_len, input int glitch_k);
    logic [16:0] w;
    logic [1:0]  f;
    w = {data, (odd ? ~^data : ^data)};
    send_sync(cmd, first_len);
    for (int k = 0; k < 17; k++) begin
      if (k == glitch_k) begin
        f = w[16-k] ? LO : HI;
        put(f, 2);
        put(IL, 4);
        put(f, 2);
        put(IL, SPB * (17 - k) - SPB / 2);
        break;
      end
      send_bit(w[16-k]);
    end
    put(IL, 24);
  endtask

  task automatic push(input logic [15:0] d, input logic [7:0] u);
    exp_t e;
    e.d = d;
    e.u = u;
    exp_q.push_back(e);
    n_push++;
  endtask

  task automatic expect_beat(input string tag, input int max_cycles);
    exp_t e;
    logic got;
    got = 1'b0;
    for (int i = 0; i < max_cycles && !got; i++) begin
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) got = 1'b1;
      else @(negedge aclk);
    end
    chk({tag, "_seen"}, 32'(got), 32'd1);
    e = exp_q.pop_front();
    if (got) begin
      chk({tag, "_tdata"}, 32'(m_axis_tdata), 32'(e.d));
      chk({tag, "_tuser"}, 32'(m_axis_tuser), 32'(e.u));
    end
  endtask

  task automatic word_and_check(input string tag, input logic cmd, input logic [15:0] d,
                                input logic odd, input int first_len,
                                input logic [15:0] exp_d, input logic [7:0] exp_u);
    push(exp_d, exp_u);
    fork
      send_word(cmd, d, odd, first_len, -1);
      expect_beat(tag, 500);
    join
  endtask

  int e0, b0, o0;

  initial begin
    arstn = 1'b0;
    diff = IL;
    m_axis_tready = 1'b1;
    repeat (4) @(negedge aclk);
    chk("reset_outputs",
        32'({m_axis_tvalid, m_axis_tdata, m_axis_tuser, rx_err, rx_overflow}), 32'd0);
    arstn = 1'b1;
    put(IL, 8);

    // 1-3: clean words, both sync types, odd and even parity
    e0 = err_cnt;
    word_and_check("w1234", 1'b1, 16'h1234, 1'b1, 24, 16'h1234, 8'h80);
    word_and_check("wFFFF", 1'b0, 16'hFFFF, 1'b1, 24, 16'hFFFF, 8'h40);
    word_and_check("w0000", 1'b0, 16'h0000, 1'b1, 24, 16'h0000, 8'h40);
    word_and_check("w00A5_even", 1'b0, 16'h00A5, 1'b0, 24, 16'h00A5, 8'h41);
    chk("clean_no_err", 32'(err_cnt - e0), 32'd0);

    // 4: line dropout inside data bit 5
    e0 = err_cnt;
    b0 = beats;
    send_word(1'b1, 16'h5A5A, 1'b1, 24, 5);
    chk("glitch_err_once", 32'(err_cnt - e0), 32'd1);
    chk("glitch_no_beat", 32'(beats - b0), 32'd0);
    word_and_check("after_glitch", 1'b1, 16'hC3E1, 1'b1, 24, 16'hC3E1, 8'h80);

    // 5: sync first-half length tolerance
    e0 = err_cnt;
    put(LO, 16);
    put(HI, 2);
    put(IL, 20);
    chk("sync16_err", 32'(err_cnt - e0), 32'd1);
    word_and_check("sync20", 1'b1, 16'hA5F0, 1'b1, 20, 16'hA5F0, 8'h80);
    word_and_check("sync24", 1'b0, 16'h8001, 1'b1, 24, 16'h8001, 8'h40);
    word_and_check("sync28", 1'b0, 16'h0F3C, 1'b1, 28, 16'h0F3C, 8'h40);
    e0 = err_cnt;
    put(LO, 29);
    put(HI, 3);
    put(IL, 20);
    chk("sync29_err", 32'(err_cnt - e0), 32'd1);

    // 6: back-pressure, overflow, then reset mid-word
    m_axis_tready = 1'b0;
    o0 = ovf_cnt;
    e0 = err_cnt;
    b0 = beats;
    push(16'h1357, 8'h80);
    send_word(1'b1, 16'h1357, 1'b1, 24, -1);
    send_word(1'b0, 16'hBEEF, 1'b1, 24, -1);
    chk("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
    chk("hold_tdata", 32'(m_axis_tdata), 32'h1357);
    chk("hold_tuser", 32'(m_axis_tuser), 32'h80);
    chk("overflow_once", 32'(ovf_cnt - o0), 32'd1);
    chk("overflow_no_err", 32'(err_cnt - e0), 32'd0);
    m_axis_tready = 1'b1;
    expect_beat("drain", 10);
    put(IL, 10);
    chk("drain_one_beat", 32'(beats - b0), 32'd1);

    b0 = beats;
    send_sync(1'b1, 24);
    for (int k = 0; k < 5; k++) send_bit(k[0]);
    arstn = 1'b0;
    diff = IL;
    repeat (3) @(negedge aclk);
    chk("midword_reset_outputs",
        32'({m_axis_tvalid, m_axis_tdata, m_axis_tuser, rx_err, rx_overflow}), 32'd0);
    arstn = 1'b1;
    put(IL, 20);
    chk("midword_reset_no_beat", 32'(beats - b0), 32'd0);
    word_and_check("post_reset", 1'b0, 16'h7E81, 1'b1, 24, 16'h7E81, 8'h40);

    chk("pulse_shape", 32'(viol), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("beat_total", 32'(beats), 32'(n_push));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
